// File: rtl/memory_nport_wb.sv
// memory_nport_wb: N-port pipelined Wishbone B4 on-chip RAM.
//
// Every port is an independent slave on one shared word array. Each port can
// take one request per cycle and is never stalled. Requests outside the
// memory window, or with a nonzero byte offset, get err instead of ack.
//
// Ports (port p occupies slice p of every packed vector):
//   wb_clk_i    in   clock shared by all ports
//   wb_rst_ni   in   asynchronous active-low reset
//   wb_cyc_i    in   [NUM_PORTS]              bus cycle; low aborts in-flight responses
//   wb_stb_i    in   [NUM_PORTS]              request strobe
//   wb_we_i     in   [NUM_PORTS]              1 = write, 0 = read
//   wb_adr_i    in   [32*NUM_PORTS]           byte address
//   wb_dat_i    in   [DATA_WIDTH*NUM_PORTS]   write data
//   wb_sel_i    in   [DATA_WIDTH/8*NUM_PORTS] byte lane enables
//   wb_dat_o    out  [DATA_WIDTH*NUM_PORTS]   read data; updated only by read acks
//   wb_ack_o    out  [NUM_PORTS]              one-cycle success pulse per request
//   wb_err_o    out  [NUM_PORTS]              one-cycle error pulse per request
//   wb_stall_o  out  [NUM_PORTS]              always 0
//
// Handshake: a request transfers on every rising edge where cyc & stb are high.
// Stall is never raised, so the slave is always ready. Exactly one ack or err
// pulse returns per transfer, in order. The pulse comes 1 cycle after the
// transfer (REG_OUT=0) or 2 cycles after it (REG_OUT=1). If cyc is low at an
// edge, every response of that port still in flight is dropped.

module memory_nport_wb #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          REG_OUT    = 1'b0
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic [NUM_PORTS-1:0]            wb_cyc_i,
    input  logic [NUM_PORTS-1:0]            wb_stb_i,
    input  logic [NUM_PORTS-1:0]            wb_we_i,
    input  logic [32*NUM_PORTS-1:0]         wb_adr_i,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0] wb_dat_i,
    input  logic [DATA_WIDTH/8*NUM_PORTS-1:0] wb_sel_i,
    output logic [DATA_WIDTH*NUM_PORTS-1:0] wb_dat_o,
    output logic [NUM_PORTS-1:0]            wb_ack_o,
    output logic [NUM_PORTS-1:0]            wb_err_o,
    output logic [NUM_PORTS-1:0]            wb_stall_o
);
    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned OFFS       = $clog2(BYTES);
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [32:0] MEM_BYTES  = 33'(DEPTH) << OFFS;
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0]  req, bad, wr_ok, rd_ok;
    logic [32:0]           off [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] idx [NUM_PORTS];

    // Decode the address. The offset is computed one bit wider than the
    // address, so bit 32 is the borrow and is set for addresses below
    // BASE_ADDR. Because BASE_ADDR is size-aligned, the low address bits can
    // be tested directly for alignment.
    always_comb begin
        req   = '0;
        bad   = '0;
        wr_ok = '0;
        rd_ok = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            off[p] = {1'b0, wb_adr_i[32*p +: 32]} - {1'b0, BASE_ADDR};
            idx[p] = off[p][OFFS +: ADDR_WIDTH];
            req[p] = wb_cyc_i[p] & wb_stb_i[p];
            bad[p] = off[p][32] || (off[p] >= MEM_BYTES) ||
                     ((wb_adr_i[32*p +: 32] & ALIGN_MASK) != 32'd0);
            wr_ok[p] = req[p] & ~bad[p] & wb_we_i[p];
            rd_ok[p] = req[p] & ~bad[p] & ~wb_we_i[p];
        end
    end

    // The array is not reset. Ports are visited from highest index to lowest,
    // so on a shared byte lane the lowest-index writer is assigned last and
    // wins.
    always_ff @(posedge wb_clk_i) begin
        for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_ok[p] && wb_sel_i[BYTES*p + b]) begin
                    mem[idx[p]][8*b +: 8] <= wb_dat_i[DATA_WIDTH*p + 8*b +: 8];
                end
            end
        end
    end

    // Stage 1. The array is read with the pre-edge contents, so a read that
    // collides with a same-cycle write returns the old word. The read data
    // register changes only on successful reads, which holds dat_o between
    // acks.
    logic [NUM_PORTS-1:0]  s1_vld, s1_err;
    logic [DATA_WIDTH-1:0] s1_dat [NUM_PORTS];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1_vld <= '0;
            s1_err <= '0;
            for (int p = 0; p < NUM_PORTS; p++) s1_dat[p] <= '0;
        end else begin
            s1_vld <= req;
            s1_err <= req & bad;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_ok[p]) s1_dat[p] <= mem[idx[p]];
            end
        end
    end

    assign wb_stall_o = '0;

    generate
        if (REG_OUT) begin : g_reg_out
            logic [NUM_PORTS-1:0]  s1_rd, s2_vld, s2_err;
            logic [DATA_WIDTH-1:0] s2_dat [NUM_PORTS];

            // A response sitting in stage 1 is dropped if cyc goes low at the
            // edge that would move it to stage 2.
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    s1_rd  <= '0;
                    s2_vld <= '0;
                    s2_err <= '0;
                    for (int p = 0; p < NUM_PORTS; p++) s2_dat[p] <= '0;
                end else begin
                    s1_rd  <= rd_ok;
                    s2_vld <= s1_vld & wb_cyc_i;
                    s2_err <= s1_err & wb_cyc_i;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (s1_rd[p] && wb_cyc_i[p]) s2_dat[p] <= s1_dat[p];
                    end
                end
            end

            assign wb_ack_o = s2_vld & ~s2_err;
            assign wb_err_o = s2_err;
            for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dat
                assign wb_dat_o[DATA_WIDTH*p +: DATA_WIDTH] = s2_dat[p];
            end
        end else begin : g_direct_out
            assign wb_ack_o = s1_vld & ~s1_err;
            assign wb_err_o = s1_err;
            for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dat
                assign wb_dat_o[DATA_WIDTH*p +: DATA_WIDTH] = s1_dat[p];
            end
        end
    endgenerate

endmodule
